move_arbiter: RTL and testbench
===============================

MOVE_ARBITER -- requirements
Module: move_arbiter

Interface
REQ-001 SHALL have parameter NCOLS, default 8: number of player columns, at least 2.
REQ-002 SHALL have parameter COOL_CYC, default 4: cooldown cycles after each granted move, at least 1.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all state updates on posedge CLK.
REQ-004 SHALL have port RST, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port key_l, input, 1 bit: move-left request, asynchronous to CLK, active-high.
REQ-006 SHALL have port key_r, input, 1 bit: move-right request, asynchronous to CLK, active-high.
REQ-007 SHALL have port pos, output, $clog2(NCOLS) bits: current player column, 0 = leftmost.
REQ-008 SHALL have port grant_l, output, 1 bit: one-cycle pulse when a left move is committed.
REQ-009 SHALL have port grant_r, output, 1 bit: one-cycle pulse when a right move is committed.
REQ-010 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-011 SHALL pass key_l and key_r each through a two-stage synchronizer; the FSM uses only the synchronized values sl and sr.
REQ-012 SHALL implement FSM states IDLE, MOVE, COOL and WAIT_REL.
REQ-013 In IDLE, exactly one of sl or sr high SHALL cause a transition to MOVE and latch the direction.
REQ-014 In IDLE, sl and sr both high in the same cycle SHALL cause a transition to WAIT_REL with no move and no grant.
REQ-015 In MOVE, the block SHALL update pos by one column in the latched direction, pulse the matching grant for exactly one cycle, load the cooldown counter with COOL_CYC-1, and go to COOL.
REQ-016 In COOL, the counter SHALL decrement each cycle and all requests SHALL be ignored; at count 0 the FSM SHALL go to WAIT_REL.
REQ-017 In WAIT_REL, the FSM SHALL return to IDLE only in a cycle where sl and sr are both low; a held key therefore yields exactly one move.
REQ-018 Latency: a key first sampled high at edge k SHALL produce the pos update and grant at edge k+3 (sync 2 edges, IDLE->MOVE 1 edge).
REQ-019 Boundary: a move out of range (left at 0, right at NCOLS-1) SHALL follow REQ-026/REQ-027.
REQ-020 The sum of pos arithmetic SHALL be computed modulo/saturated explicitly; pos SHALL never hold a value of NCOLS or above.
REQ-021 grant_l and grant_r SHALL never be high in the same cycle.

Reset
REQ-022 While RST is high, the block SHALL immediately force pos = NCOLS/2 (integer division), grant_l = grant_r = 0, busy = 0, state IDLE, cooldown counter 0 and synchronizer flops 0.
REQ-023 A reset asserted in MOVE, COOL or WAIT_REL SHALL abort the sequence with no grant pulse, and no latched direction SHALL survive the reset.
REQ-024 After RST falls, the first move SHALL require a fresh synchronized request, per REQ-018.

Configuration
REQ-025 Macro MOVE_WRAP_EN SHALL select the edge behaviour of pos.
REQ-026 With MOVE_WRAP_EN defined: left at 0 SHALL set pos to NCOLS-1, right at NCOLS-1 SHALL set pos to 0, and the grant SHALL pulse.
REQ-027 Without MOVE_WRAP_EN: an out-of-range move SHALL leave pos unchanged with no grant, while the FSM still passes through COOL and WAIT_REL.

Structure
REQ-028 Shared package asteroid_pkg SHALL hold the move_state_t enum (IDLE, MOVE, COOL, WAIT_REL), the dir_t enum (DIR_L, DIR_R) and the constant NCOLS_DEF = 8.
REQ-029 The synchronizer SHALL be the sub-module sync2 (two flops with asynchronous active-high reset, reset value 0), instantiated once per key.

Verification (NCOLS=8, COOL_CYC=4)
REQ-030 Reset then idle: pos=4, grants 0, busy 0; key_l pulsed high for 1 cycle -> at edge k+3 pos=3 and grant_l high exactly 1 cycle; busy stays high until both keys are low after COOL.
REQ-031 key_r held high 20 cycles from pos=4 -> exactly one grant_r, pos=5; after release, a second press -> pos=6.
REQ-032 key_l and key_r rising in the same cycle -> no grant, pos unchanged, FSM in WAIT_REL until both keys are low.
REQ-033 pos=0 and key_l pressed -> with MOVE_WRAP_EN pos=7 and grant_l pulses; without it pos=0 and no grant_l.
REQ-034 RST asserted mid-COOL at pos=3 -> in the same cycle pos=4, busy=0 and grants 0; the next press then follows REQ-018 timing.
REQ-035 A key press during COOL (released before WAIT_REL) -> no second move.

Source files
------------

// File: rtl/asteroid_pkg.sv
// Shared types for the player-move arbiter: FSM states, move direction,
// and the default column count.
package asteroid_pkg;

  localparam int NCOLS_DEF = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MOVE     = 2'd1,
    COOL     = 2'd2,
    WAIT_REL = 2'd3
  } move_state_t;

  typedef enum logic {
    DIR_L = 1'b0,
    DIR_R = 1'b1
  } dir_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level input.
// Both flops clear to 0 on reset.
module sync2 (
  input  logic CLK,
  input  logic RST,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Shift the async input through two flops to settle metastability
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/move_arbiter.sv
// Player-move arbiter: turns asynchronous left/right key levels into
// single committed column moves with a cooldown and a release gate, so a
// held key moves exactly once.
// Build option: define MOVE_WRAP_EN to wrap pos at the edges; otherwise
// out-of-range moves are dropped (no pos change, no grant).
module move_arbiter
  import asteroid_pkg::*;
#(
  parameter  int NCOLS    = NCOLS_DEF,
  parameter  int COOL_CYC = 4,
  localparam int PW       = $clog2(NCOLS),
  localparam int CW       = $clog2(COOL_CYC + 1)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          key_l,
  input  logic          key_r,
  output logic [PW-1:0] pos,
  output logic          grant_l,
  output logic          grant_r,
  output logic          busy
);

  logic sl, sr;

  sync2 u_sync_l (.CLK(CLK), .RST(RST), .d(key_l), .q(sl));
  sync2 u_sync_r (.CLK(CLK), .RST(RST), .d(key_r), .q(sr));

  move_state_t   state_q, state_d;
  dir_t          dir_q,   dir_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [PW-1:0] pos_q,   pos_d;
  logic          gl_q,    gl_d;
  logic          gr_q,    gr_d;

  // Next-state logic: request decode, move commit, cooldown, release gate
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    pos_d   = pos_q;
    gl_d    = 1'b0;
    gr_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sl ^ sr) begin
          state_d = MOVE;
          dir_d   = sl ? DIR_L : DIR_R;
        end else if (sl && sr) begin
          // Conflicting request: no move, just wait for both to drop
          state_d = WAIT_REL;
        end
      end
      MOVE: begin
        cnt_d   = CW'(COOL_CYC - 1);
        state_d = COOL;
        if (dir_q == DIR_L) begin
          if (pos_q != '0) begin
            pos_d = pos_q - PW'(1);
            gl_d  = 1'b1;
          end else begin
`ifdef MOVE_WRAP_EN
            pos_d = PW'(NCOLS - 1);
            gl_d  = 1'b1;
`else
            pos_d = pos_q;
`endif
          end
        end else begin
          if (pos_q != PW'(NCOLS - 1)) begin
            pos_d = pos_q + PW'(1);
            gr_d  = 1'b1;
          end else begin
`ifdef MOVE_WRAP_EN
            pos_d = '0;
            gr_d  = 1'b1;
`else
            pos_d = pos_q;
`endif
          end
        end
      end
      COOL: begin
        // Requests are ignored entirely while cooling down
        if (cnt_q == '0) state_d = WAIT_REL;
        else             cnt_d   = cnt_q - CW'(1);
      end
      WAIT_REL: begin
        if (!sl && !sr) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset aborts any sequence and forgets the direction
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      dir_q   <= DIR_L;
      cnt_q   <= '0;
      pos_q   <= PW'(NCOLS / 2);
      gl_q    <= 1'b0;
      gr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      gl_q    <= gl_d;
      gr_q    <= gr_d;
    end
  end

  assign pos     = pos_q;
  assign grant_l = gl_q;
  assign grant_r = gr_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_move_arbiter.sv
// Self-checking bench for move_arbiter (NCOLS=8, COOL_CYC=4). A timeline
// reference model predicts pos/grants/busy after every clock edge.
module tb_move_arbiter;

  localparam int NCOLS    = 8;
  localparam int COOL_CYC = 4;
  localparam int PW       = $clog2(NCOLS);

  logic          CLK   = 1'b0;
  logic          RST   = 1'b1;
  logic          key_l = 1'b0;
  logic          key_r = 1'b0;
  logic [PW-1:0] pos;
  logic          grant_l, grant_r, busy;

  int tests = 0;
  int fails = 0;
  int gl_cnt = 0;
  int gr_cnt = 0;

  move_arbiter #(.NCOLS(NCOLS), .COOL_CYC(COOL_CYC)) dut (
    .CLK(CLK), .RST(RST), .key_l(key_l), .key_r(key_r),
    .pos(pos), .grant_l(grant_l), .grant_r(grant_r), .busy(busy)
  );

  always #5 CLK = ~CLK;

  // Reference model: key history delayed two edges, plus a timeline of
  // when the committed move lands and from which edge release is allowed.
  int m_pos;
  bit m_busy, m_dir_l, m_gl, m_gr;
  int m_move_at, m_rel_from, edge_n;
  bit s1l, s2l, s1r, s2r;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pos = NCOLS / 2; m_busy = 0; m_dir_l = 0; m_gl = 0; m_gr = 0;
    m_move_at = -1; m_rel_from = 0;
    s1l = 0; s2l = 0; s1r = 0; s2r = 0;
  endtask

  task automatic model_edge();
    bit sl, sr;
    sl = s2l; sr = s2r;
    m_gl = 0; m_gr = 0;
    if (m_move_at == edge_n) begin
      if (m_dir_l) begin
        if (m_pos > 0) begin m_pos = m_pos - 1; m_gl = 1; end
`ifdef MOVE_WRAP_EN
        else begin m_pos = NCOLS - 1; m_gl = 1; end
`endif
      end else begin
        if (m_pos < NCOLS - 1) begin m_pos = m_pos + 1; m_gr = 1; end
`ifdef MOVE_WRAP_EN
        else begin m_pos = 0; m_gr = 1; end
`endif
      end
      m_move_at = -1;
    end else if (!m_busy) begin
      if (sl != sr) begin
        m_busy = 1; m_dir_l = sl;
        m_move_at  = edge_n + 1;
        m_rel_from = edge_n + 2 + COOL_CYC;
      end else if (sl && sr) begin
        m_busy = 1;
        m_rel_from = edge_n + 1;
      end
    end else if (edge_n >= m_rel_from && !sl && !sr) begin
      m_busy = 0;
    end
    s2l = s1l; s1l = key_l;
    s2r = s1r; s1r = key_r;
  endtask

  task automatic check_all();
    chk("pos", 32'(pos), 32'(m_pos));
    chk("grant_l", 32'(grant_l), 32'(m_gl));
    chk("grant_r", 32'(grant_r), 32'(m_gr));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("grant_excl", 32'(grant_l & grant_r), 32'd0);
  endtask

  // One clock edge: advance the model, then sample the DUT just after
  task automatic step();
    @(posedge CLK);
    if (RST) model_reset();
    else     model_edge();
    edge_n++;
    #1;
    if (grant_l === 1'b1) gl_cnt++;
    if (grant_r === 1'b1) gr_cnt++;
    check_all();
  endtask

  task automatic press(input bit l, input bit r, input int hold, input int tail);
    key_l = l; key_r = r;
    repeat (hold) step();
    key_l = 0; key_r = 0;
    repeat (tail) step();
  endtask

  initial begin
    edge_n = 0;
    model_reset();
    repeat (3) step();
    chk("rst_pos", 32'(pos), 32'd4);
    chk("rst_busy", 32'(busy), 32'd0);
    RST = 0;

    // Single-cycle left press from reset: grant exactly at k+3
    gl_cnt = 0;
    press(1, 0, 1, 2);
    chk("lat_k2_grant", 32'(grant_l), 32'd0);
    step();
    chk("lat_k3_grant", 32'(grant_l), 32'd1);
    chk("lat_k3_pos", 32'(pos), 32'd3);
    repeat (10) step();
    chk("left_once", 32'(gl_cnt), 32'd1);
    chk("idle_after", 32'(busy), 32'd0);

    // Right held for 20 cycles moves once; second press moves again
    gr_cnt = 0;
    press(0, 1, 20, 4);
    chk("held_once", 32'(gr_cnt), 32'd1);
    chk("held_pos", 32'(pos), 32'd4);
    press(0, 1, 2, 10);
    chk("second_pos", 32'(pos), 32'd5);

    // Simultaneous press: no move, busy until release
    gl_cnt = 0; gr_cnt = 0;
    press(1, 1, 6, 0);
    chk("both_busy", 32'(busy), 32'd1);
    repeat (6) step();
    chk("both_nogrant", 32'(gl_cnt + gr_cnt), 32'd0);
    chk("both_pos", 32'(pos), 32'd5);
    chk("both_idle", 32'(busy), 32'd0);

    // Press during cooldown, released before release gate: no second move
    gl_cnt = 0;
    press(1, 0, 1, 4);
    press(1, 0, 2, 12);
    chk("cool_ignore_cnt", 32'(gl_cnt), 32'd1);
    chk("cool_ignore_pos", 32'(pos), 32'd4);

    // Walk to column 0, then exercise the left edge
    for (int i = 0; i < NCOLS && m_pos != 0; i++) press(1, 0, 2, 10);
    chk("edge_at0", 32'(pos), 32'd0);
    gl_cnt = 0;
    press(1, 0, 2, 10);
`ifdef MOVE_WRAP_EN
    chk("edge_wrap_pos", 32'(pos), 32'd7);
    chk("edge_wrap_gnt", 32'(gl_cnt), 32'd1);
`else
    chk("edge_sat_pos", 32'(pos), 32'd0);
    chk("edge_sat_gnt", 32'(gl_cnt), 32'd0);
`endif

    // Reset asserted mid-cooldown at pos=3
    RST = 1; step(); RST = 0;
    press(1, 0, 1, 5);
    chk("pre_rst_pos", 32'(pos), 32'd3);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #3 RST = 1;
    #1;
    chk("async_rst_pos", 32'(pos), 32'd4);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_gnt", 32'({grant_l, grant_r}), 32'd0);
    step();
    RST = 0;
    press(0, 1, 1, 2);
    chk("post_rst_k2", 32'(grant_r), 32'd0);
    step();
    chk("post_rst_k3", 32'(grant_r), 32'd1);
    chk("post_rst_pos", 32'(pos), 32'd5);
    repeat (8) step();

    // Randomized key traffic against the model
    for (int i = 0; i < 60; i++) begin
      int mode;
      mode = int'($urandom_range(0, 5));
      case (mode)
        0, 1:    press(1, 0, int'($urandom_range(1, 12)), int'($urandom_range(0, 12)));
        2, 3:    press(0, 1, int'($urandom_range(1, 12)), int'($urandom_range(0, 12)));
        4:       press(1, 1, int'($urandom_range(1, 6)),  int'($urandom_range(0, 8)));
        default: press(0, 0, 0, int'($urandom_range(1, 6)));
      endcase
    end
    repeat (12) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
